// File: rtl/t08_lcd_bus_arbiter.sv
// Two-port round-robin arbiter and WRX strobe sequencer for a write-only 8080-style LCD bus; CSX held per transaction.
// Optional GAP-idle forced release when T08_LCD_ARB_TIMEOUT_EN is defined.
module t08_lcd_bus_arbiter #(
   parameter int WR_LOW      = 2,
   parameter int WR_HIGH     = 2,
   parameter int GAP_TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req0_dcx,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic       req1_dcx,
   input  logic       req1_last,
   output logic       req1_ready,
   output logic [7:0] spi_outputs,
   output logic       spi_wrx,
   output logic       spi_rdx,
   output logic       spi_csx,
   output logic       spi_dcx,
   output logic [1:0] grant,
   output logic       busy,
   output logic       timeout
);

   localparam int PH_MAX = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
   localparam int CW     = $clog2(PH_MAX) + 1;
   localparam logic [CW-1:0] LO_LOAD = CW'(WR_LOW - 1);
   localparam logic [CW-1:0] HI_LOAD = CW'(WR_HIGH - 1);

   if (WR_LOW < 1 || WR_HIGH < 1 || GAP_TIMEOUT < 1) begin : g_param_check
      $error("t08_lcd_bus_arbiter: WR_LOW, WR_HIGH and GAP_TIMEOUT must be >= 1");
   end

   typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, GAP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          owner_q, owner_d;
   logic          ptr_q, ptr_d;
   logic          last_q, last_d;
   logic          dcx_q, dcx_d;
   logic [7:0]    data_q, data_d;
   logic          csx_q, wrx_q;
   logic [1:0]    grant_q;
   logic          accept, sel, owner_vld;

`ifdef T08_LCD_ARB_TIMEOUT_EN
   localparam int GW = $clog2(GAP_TIMEOUT + 1);
   logic [GW-1:0] gap_q, gap_d;
   logic          timeout_q, timeout_d;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      last_d    = last_q;
      dcx_d     = dcx_q;
      data_d    = data_q;
      accept    = 1'b0;
      sel       = owner_q;
      owner_vld = owner_q ? req1_valid : req0_valid;
`ifdef T08_LCD_ARB_TIMEOUT_EN
      gap_d     = '0;
      timeout_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            // Pointer-preferred port wins; otherwise whichever one is valid.
            sel    = ptr_q ? req1_valid : !req0_valid;
            accept = req0_valid | req1_valid;
         end
         WR_LO: begin
            if (cnt_q == '0) begin
               state_d = WR_HI;
               cnt_d   = HI_LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WR_HI: begin
            if (cnt_q == '0) begin
               if (last_q) begin
                  state_d = IDLE;
                  ptr_d   = ~owner_q;
               end else begin
                  state_d = GAP;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAP: begin
            accept = owner_vld;
`ifdef T08_LCD_ARB_TIMEOUT_EN
            if (!owner_vld) begin
               if (gap_q == GW'(GAP_TIMEOUT - 1)) begin
                  state_d   = IDLE;
                  ptr_d     = ~owner_q;
                  timeout_d = 1'b1;
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
`endif
         end
         default: state_d = IDLE;
      endcase
      if (accept) begin
         owner_d = sel;
         data_d  = sel ? req1_data : req0_data;
         dcx_d   = sel ? req1_dcx  : req0_dcx;
         last_d  = sel ? req1_last : req0_last;
         state_d = WR_LO;
         cnt_d   = LO_LOAD;
      end
   end

   assign req0_ready = accept && !sel && !reset;
   assign req1_ready = accept &&  sel && !reset;

   // Bus strobes are registered from the next state so they change on the same edge as the FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         owner_q <= 1'b0;
         ptr_q   <= 1'b0;
         last_q  <= 1'b0;
         dcx_q   <= 1'b1;
         data_q  <= 8'h00;
         csx_q   <= 1'b1;
         wrx_q   <= 1'b1;
         grant_q <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         last_q  <= last_d;
         dcx_q   <= dcx_d;
         data_q  <= data_d;
         csx_q   <= (state_d == IDLE);
         wrx_q   <= (state_d != WR_LO);
         grant_q <= (state_d == IDLE) ? 2'b00 : (owner_d ? 2'b10 : 2'b01);
      end
   end

`ifdef T08_LCD_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gap_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         gap_q     <= gap_d;
         timeout_q <= timeout_d;
      end
   end
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign spi_outputs = data_q;
   assign spi_dcx     = dcx_q;
   assign spi_csx     = csx_q;
   assign spi_wrx     = wrx_q;
   assign spi_rdx     = 1'b1;
   assign grant       = grant_q;
   assign busy        = (state_q != IDLE);

endmodule
